// File: rtl/imem_switch_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared types and constants for the switch-driven instruction-memory loader.
//   loader_state_e    : FSM state encoding (IDLE, COLLECT, WRITE, FULL)
//   NIBBLES_PER_WORD  : hex digits keyed per 32-bit word
//   NIBBLE_W          : bits per keyed digit
//   WORD_W / COUNT_W  : derived word and digit-counter widths
//   shift_in_nibble() : appends one digit at the LSB end, MSB digit keyed first
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package imem_loader_pkg;

  localparam int NIBBLES_PER_WORD = 8;
  localparam int NIBBLE_W         = 4;
  localparam int WORD_W           = NIBBLES_PER_WORD * NIBBLE_W;
  localparam int COUNT_W          = $clog2(NIBBLES_PER_WORD);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_FULL    = 2'd3
  } loader_state_e;

  // Older digits move toward the MSB, so the first key press ends up as
  // the most significant nibble once the word is complete.
  function automatic logic [WORD_W-1:0] shift_in_nibble(
    input logic [WORD_W-1:0]   word,
    input logic [NIBBLE_W-1:0] nib
  );
    return {word[WORD_W-NIBBLE_W-1:0], nib};
  endfunction

endpackage

// File: rtl/imem_switch_loader_if.sv
// -----------------------------------------------------------------------------
// imem_switch_loader_if
// Bundles the board-side raw inputs and the memory/feedback outputs of the
// loader.
//   Inputs to loader  : load_mode (switch), nibble[3:0] (switches), enter (button)
//   Outputs of loader : wr_en, wr_addr, wr_data, cpu_hold, shadow, nib_count,
//                       full, plus debug views dbg_state and dbg_enter_level
// Modports:
//   master : the loader (drives outputs, reads raw inputs)
//   slave  : the board / environment (drives raw inputs, reads outputs)
//
// Write handshake: wr_en is a fire-and-forget strobe with no ready. The memory
// must take wr_addr/wr_data in the single cycle wr_en is high; there is no
// back-pressure and wr_en is never held for more than one cycle per word.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface imem_switch_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  import imem_loader_pkg::*;

  logic                  load_mode;
  logic [NIBBLE_W-1:0]   nibble;
  logic                  enter;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [WORD_W-1:0]     wr_data;
  logic                  cpu_hold;
  logic [WORD_W-1:0]     shadow;
  logic [COUNT_W-1:0]    nib_count;
  logic                  full;

  loader_state_e         dbg_state;
  logic                  dbg_enter_level;

  modport master (
    input  load_mode, nibble, enter,
    output wr_en, wr_addr, wr_data, cpu_hold, shadow, nib_count, full,
    output dbg_state, dbg_enter_level
  );

  modport slave (
    output load_mode, nibble, enter,
    input  wr_en, wr_addr, wr_data, cpu_hold, shadow, nib_count, full,
    input  dbg_state, dbg_enter_level
  );

endinterface

// File: rtl/imem_switch_loader_button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
// Synchronizes a bouncy push button, filters it, and emits one pulse per press.
//   clock  in  : single clock
//   reset  in  : asynchronous active-high, clears all flops
//   raw    in  : raw button level (asynchronous to clock)
//   level  out : debounced button level
//   press  out : one-cycle pulse on each debounced rising edge
// Latency from a clean raw rising edge to press is 2 + DEBOUNCE_CYCLES + 1:
// two synchronizer stages, DEBOUNCE_CYCLES mismatch samples, one edge stage.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  // The counter only has to reach DEBOUNCE_CYCLES-1; the flip happens on the
  // sample that would take it to DEBOUNCE_CYCLES.
  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             level_prev_q;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    // Any sample that agrees with the accepted level restarts the count,
    // so a bounce resets the filter instead of merely pausing it.
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    press_d = level_q & ~level_prev_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= raw;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      press_q      <= press_d;
      cnt_q        <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/imem_switch_loader.sv
// -----------------------------------------------------------------------------
// imem_switch_loader
// Writes a program into instruction memory from slide switches and a button.
// The operator keys each 32-bit word as 8 hex digits, MSB digit first, one
// button press per digit; each completed word is written once at an
// auto-incrementing word address. The CPU is held in reset while loading.
//   clock      in  : single clock, all state on rising edge
//   reset      in  : asynchronous active-high
//   bus.load_mode  in  : raw switch, 1 = loading
//   bus.nibble     in  : raw switches, next hex digit
//   bus.enter      in  : raw bouncy push button
//   bus.wr_en      out : one-cycle write strobe per completed word
//   bus.wr_addr    out : word address of current or next write
//   bus.wr_data    out : word being written (same as shadow)
//   bus.cpu_hold   out : registered, high while the FSM is not IDLE
//   bus.shadow     out : partially assembled word for LED feedback
//   bus.nib_count  out : digits accepted in the current word, 0..7
//   bus.full       out : last address written, further words refused
//   bus.dbg_state / bus.dbg_enter_level out : FSM state and debounced button
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module imem_switch_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH      = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clock,
  input  logic                reset,
  imem_switch_loader_if.master bus
);

  localparam logic [1:0] IDLE    = ST_IDLE;
  localparam logic [1:0] COLLECT = ST_COLLECT;
  localparam logic [1:0] WRITE   = ST_WRITE;
  localparam logic [1:0] FULL    = ST_FULL;

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = '1;
  localparam logic [COUNT_W-1:0]    COUNT_LAST = COUNT_W'(NIBBLES_PER_WORD - 1);

  // Synchronizers for the slow switches
  logic                load_s1_q, load_s2_q;
  logic [NIBBLE_W-1:0] nib_s1_q, nib_s2_q;

  // FSM and datapath
  logic [1:0]            state_q, state_d;
  logic [WORD_W-1:0]     shadow_q, shadow_d;
  logic [COUNT_W-1:0]    count_q, count_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  cpu_hold_q;

  logic enter_level;
  logic press;

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_enter_debouncer (
    .clock (clock),
    .reset (reset),
    .raw   (bus.enter),
    .level (enter_level),
    .press (press)
  );

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    count_d  = count_q;
    addr_d   = addr_q;

    case (state_q)
      IDLE: begin
        // Entering a new load session restarts from address 0 with a
        // clean word; shadow is otherwise left alone in IDLE for LED feedback.
        if (load_s2_q) begin
          state_d  = COLLECT;
          shadow_d = '0;
          count_d  = '0;
          addr_d   = '0;
        end
      end

      COLLECT: begin
        // Leaving load mode wins over a simultaneous press.
        if (!load_s2_q) begin
          state_d = IDLE;
        end else if (press) begin
          shadow_d = shift_in_nibble(shadow_q, nib_s2_q);
          count_d  = count_q + 1'b1;
          if (count_q == COUNT_LAST) begin
            state_d = WRITE;
          end
        end
      end

      WRITE: begin
        // The write strobe is issued in this state regardless of load_mode;
        // only the successor state depends on it.
        if (addr_q != ADDR_LAST) begin
          addr_d = addr_q + 1'b1;
        end
        if (!load_s2_q) begin
          state_d = IDLE;
        end else if (addr_q == ADDR_LAST) begin
          state_d = FULL;
        end else begin
          state_d = COLLECT;
        end
      end

      FULL: begin
        if (!load_s2_q) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      load_s1_q  <= 1'b0;
      load_s2_q  <= 1'b0;
      nib_s1_q   <= '0;
      nib_s2_q   <= '0;
      state_q    <= IDLE;
      shadow_q   <= '0;
      count_q    <= '0;
      addr_q     <= '0;
      cpu_hold_q <= 1'b0;
    end else begin
      load_s1_q  <= bus.load_mode;
      load_s2_q  <= load_s1_q;
      nib_s1_q   <= bus.nibble;
      nib_s2_q   <= nib_s1_q;
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      // Registered from the current state, so the CPU is released one
      // cycle after IDLE is entered.
      cpu_hold_q <= (state_q != IDLE);
    end
  end

  assign bus.wr_en           = (state_q == WRITE);
  assign bus.wr_addr         = addr_q;
  assign bus.wr_data         = shadow_q;
  assign bus.cpu_hold        = cpu_hold_q;
  assign bus.shadow          = shadow_q;
  assign bus.nib_count       = count_q;
  assign bus.full            = (state_q == FULL);
  assign bus.dbg_state       = loader_state_e'(state_q);
  assign bus.dbg_enter_level = enter_level;

endmodule
